point_serializer: RTL and testbench

- Downstream consumer of scalarmult / scalarmultB affine results (px, py).
- Captures one point through the 4-phase res_valid/res_ready handshake and emits it as a little-endian byte stream (RFC 7748 style: x bytes 0..55, then y bytes 0..55).
- The byte stream uses a valid/ready interface and feeds a UART or host link.
- Replaces the compare-and-count logic currently in the top-level harness.

---
 rtl/point_serializer.sv | 114 +++++++++++
 tb/tb_point_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/point_serializer.sv
// point_serializer: captures one affine point (px, py) via a 4-phase handshake and
// streams it little-endian, x then y, over valid/ready. Optional macro: POINT_SERIALIZER_CANON_REDUCE_EN.
module point_serializer #(
    parameter int N      = 448,
    parameter int WITH_Y = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    input  logic         res_valid,
    output logic         res_ready,
    output logic [7:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         busy
);

    localparam int NB    = N / 8;
    localparam int TOTAL = (WITH_Y != 0) ? 2 * NB : NB;
    localparam int SW    = 8 * TOTAL;
    localparam int CW    = $clog2(2 * NB + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_res_ready;
    logic [SW-1:0]   r_shift;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   w_load;
    logic [N-1:0]    w_px;
    logic [N-1:0]    w_py;
    logic            w_capture;
    logic            w_accept;
    logic            w_last;

`ifdef POINT_SERIALIZER_CANON_REDUCE_EN
    // P448 = 2^448 - 2^224 - 1; only meaningful for N = 448
    localparam logic [N-1:0] P448 = {{(N-225){1'b1}}, 1'b0, {224{1'b1}}};

    assign w_px = (px >= P448) ? (px - P448) : px;
    assign w_py = (py >= P448) ? (py - P448) : py;
`else
    assign w_px = px;
    assign w_py = py;
`endif

    generate
        if (WITH_Y != 0) begin : g_xy
            assign w_load = {w_py, w_px};
        end else begin : g_x
            assign w_load = w_px;
        end
    endgenerate

    assign w_capture = (r_state == IDLE) && res_valid && !r_res_ready;
    assign w_accept  = (r_state == SEND) && dout_ready;
    assign w_last    = (r_cnt == CW'(TOTAL - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_state_nxt = SEND;
            SEND:    if (w_accept && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout_valid = (r_state == SEND);
        busy       = (r_state == SEND);
        dout_last  = (r_state == SEND) && w_last;
        dout       = (r_state == SEND) ? r_shift[7:0] : '0;
        res_ready  = r_res_ready;
    end

    // res_ready follows res_valid low independently of state, so it may drop mid-frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_ready <= 1'b0;
        end else if (!res_valid) begin
            r_res_ready <= 1'b0;
        end else if (w_capture) begin
            r_res_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_shift <= w_load;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= r_shift >> 8;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_point_serializer.sv
// Directed bench for point_serializer (N=448, WITH_Y=1); honours POINT_SERIALIZER_CANON_REDUCE_EN.
module tb_point_serializer;

    localparam int N     = 448;
    localparam int TOTAL = 112;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] px;
    logic [N-1:0] py;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         busy;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   exp_b [0:TOTAL-1];

    point_serializer #(.N(N), .WITH_Y(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .px         (px),
        .py         (py),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < TOTAL; i++) exp_b[i] = 8'h00;
    endtask

    // Receives nmax bytes; each cycle the presented byte must match the next expected one
    task automatic recv(input string name, input bit stall, input int nmax);
        int n   = 0;
        int cyc = 0;
        while (n < nmax && cyc < 2000) begin
            dout_ready = stall ? cyc[0] : 1'b1;
            check($sformatf("%s_valid_b%0d", name, n), 64'(dout_valid), 64'd1);
            if (dout_valid !== 1'b1) break;
            check($sformatf("%s_data_b%0d", name, n), 64'(dout), 64'(exp_b[n]));
            check($sformatf("%s_last_b%0d", name, n), 64'(dout_last), 64'(n == TOTAL - 1));
            if (dout_ready) n++;
            tick();
            cyc++;
        end
        check($sformatf("%s_count", name), 64'(n), 64'(nmax));
    endtask

    task automatic check_idle(input string name);
        check($sformatf("%s_busy", name), 64'(busy), 64'd0);
        check($sformatf("%s_dvalid", name), 64'(dout_valid), 64'd0);
        check($sformatf("%s_dlast", name), 64'(dout_last), 64'd0);
    endtask

    initial begin
        int extra;
        logic [N:0] p448;

        // Reset held with res_valid high: nothing may be captured
        rstn       = 1'b0;
        res_valid  = 1'b1;
        dout_ready = 1'b0;
        px         = N'(1);
        py         = N'(2);
        repeat (3) tick();
        check("rst_res_ready", 64'(res_ready), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check_idle("rst");

        rstn = 1'b1;
        tick();
        check("cap1_res_ready", 64'(res_ready), 64'd1);
        check("cap1_dvalid", 64'(dout_valid), 64'd1);
        check("cap1_busy", 64'(busy), 64'd1);
        check("cap1_dout", 64'(dout), 64'h01);

        res_valid = 1'b0;
        tick();
        check("cap1_res_ready_clr", 64'(res_ready), 64'd0);
        check("cap1_hold_dout", 64'(dout), 64'h01);
        clear_exp();
        exp_b[0]  = 8'h01;
        exp_b[56] = 8'h02;
        recv("basic", 1'b0, TOTAL);
        check_idle("basic_end");

        // Backpressure with a distinct byte in every position
        for (int i = 0; i < 56; i++) begin
            px[8*i +: 8] = 8'(56 - i);
            py[8*i +: 8] = 8'(8'h80 + i);
            exp_b[i]      = 8'(56 - i);
            exp_b[56 + i] = 8'(8'h80 + i);
        end
        dout_ready = 1'b0;
        res_valid  = 1'b1;
        tick();
        check("cap2_res_ready", 64'(res_ready), 64'd1);
        res_valid = 1'b0;
        recv("bp", 1'b1, TOTAL);
        check_idle("bp_end");

        // Canonical reduction: px = P448 + 5
        p448 = (449'd1 << 448) - (449'd1 << 224) - 449'd1;
        px   = N'(p448 + 449'd5);
        py   = '0;
        clear_exp();
`ifdef POINT_SERIALIZER_CANON_REDUCE_EN
        exp_b[0] = 8'h05;
`else
        exp_b[0] = 8'h04;
        for (int i = 28; i < 56; i++) exp_b[i] = 8'hFF;
`endif
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        recv("canon", 1'b0, TOTAL);
        check_idle("canon_end");

        // res_valid held high for 300 cycles: exactly one frame
        px = N'(8'h11);
        py = N'(8'h22);
        clear_exp();
        exp_b[0]  = 8'h11;
        exp_b[56] = 8'h22;
        res_valid = 1'b1;
        tick();
        recv("hold", 1'b0, TOTAL);
        extra = 0;
        for (int i = 0; i < 187; i++) begin
            if (dout_valid !== 1'b0 || busy !== 1'b0) extra++;
            tick();
        end
        check("hold_no_second_frame", 64'(extra), 64'd0);
        check("hold_res_ready", 64'(res_ready), 64'd1);

        res_valid = 1'b0;
        tick();
        check("hold_res_ready_drop", 64'(res_ready), 64'd0);
        check("hold_no_cap_low", 64'(dout_valid), 64'd0);
        res_valid = 1'b1;
        tick();
        check("hold_res_ready_rise", 64'(res_ready), 64'd1);
        res_valid = 1'b0;
        recv("hold2", 1'b0, TOTAL);
        check_idle("hold2_end");

        // Mid-frame reset after byte 30 is accepted
        for (int i = 0; i < 56; i++) begin
            px[8*i +: 8] = 8'(56 - i);
            py[8*i +: 8] = 8'(8'h80 + i);
            exp_b[i]      = 8'(56 - i);
            exp_b[56 + i] = 8'(8'h80 + i);
        end
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        recv("mid", 1'b0, 31);
        rstn = 1'b0;
        #1;
        check("mid_rst_res_ready", 64'(res_ready), 64'd0);
        check("mid_rst_dout", 64'(dout), 64'd0);
        check_idle("mid_rst");
        dout_ready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        px = N'(3);
        py = '0;
        clear_exp();
        exp_b[0]  = 8'h03;
        res_valid = 1'b1;
        tick();
        check("mid_cap_dout", 64'(dout), 64'h03);
        res_valid = 1'b0;
        recv("mid2", 1'b0, TOTAL);
        check_idle("mid2_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
